// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAP  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   localparam int unsigned SEC_LO_MAX = 9;
   localparam int unsigned SEC_HI_MAX = 5;
   localparam int unsigned MIN_LO_MAX = 9;
   localparam int unsigned MIN_HI_MAX = 5;

   typedef struct packed {
      logic [3:0] mh;
      logic [3:0] ml;
      logic [3:0] sh;
      logic [3:0] sl;
   } bcd_time_t;

   // Prescaler width: clog2 of the divider, never narrower than one bit.
   function automatic int unsigned presc_width(input int unsigned div);
      return (div <= 1) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/bcd_digit_en.sv
// One enable-driven BCD digit that wraps to zero after LIMIT.
module bcd_digit_en #(
   parameter int unsigned LIMIT = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       at_limit
);

   assign at_limit = (digit == 4'(LIMIT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          digit <= 4'd0;
      else if (clr)        digit <= 4'd0;
      else if (en)         digit <= at_limit ? 4'd0 : digit + 4'd1;
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/clear stopwatch: button edge detect, FSM, 1 s prescaler,
// cascaded BCD counter, lap latch and registered display outputs.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic [3:0] BCD_SL,
   output logic [3:0] BCD_SH,
   output logic [3:0] BCD_ML,
   output logic [3:0] BCD_MH,
   output logic       running,
   output logic       lap_active,
   output logic       wrap
);

   localparam int unsigned PW = presc_width(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   state_t      state, state_next;
   logic        prev_start, prev_lap, prev_clear;
   logic        win_start, win_lap, win_clear;
   logic        cnt_clr, lap_load, counting, tick, carry_out;
   logic [PW-1:0] presc;
   logic        en_sl, en_sh, en_ml, en_mh;
   logic        lim_sl, lim_sh, lim_ml, lim_mh;
   bcd_time_t   cnt, lap_reg, disp;

   // Prev registers reset high so a button held through reset is not an event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_start <= 1'b1;
         prev_lap   <= 1'b1;
         prev_clear <= 1'b1;
      end else begin
         prev_start <= btn_start;
         prev_lap   <= btn_lap;
         prev_clear <= btn_clear;
      end
   end

   // Only the highest-priority event (clear > start > lap) survives.
   assign win_clear = btn_clear & ~prev_clear;
   assign win_start = btn_start & ~prev_start & ~win_clear;
   assign win_lap   = btn_lap & ~prev_lap & ~win_clear & ~(btn_start & ~prev_start);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      lap_load   = 1'b0;
      case (state)
         ST_IDLE: if (win_start) state_next = ST_RUN;
         ST_RUN: begin
            if (win_start) state_next = ST_STOP;
            else if (win_lap) begin
               state_next = ST_LAP;
               lap_load   = 1'b1;
            end
         end
         ST_LAP: begin
            if (win_lap)        state_next = ST_RUN;
            else if (win_start) state_next = ST_STOP;
         end
         ST_STOP: begin
            if (win_clear) begin
               state_next = ST_IDLE;
               cnt_clr    = 1'b1;
            end else if (win_start) begin
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign counting = (state == ST_RUN) || (state == ST_LAP);
   assign tick     = counting && (presc == PRESC_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        presc <= '0;
      else if (cnt_clr)  presc <= '0;
      else if (counting) presc <= tick ? '0 : presc + PW'(1);
   end

   // Single-cycle combinational carry chain across the four digits.
   assign en_sl     = tick;
   assign en_sh     = en_sl & lim_sl;
   assign en_ml     = en_sh & lim_sh;
   assign en_mh     = en_ml & lim_ml;
   assign carry_out = en_mh & lim_mh;

   bcd_digit_en #(.LIMIT(SEC_LO_MAX)) u_sl (.clk(clk), .reset(reset), .en(en_sl), .clr(cnt_clr), .digit(cnt.sl), .at_limit(lim_sl));
   bcd_digit_en #(.LIMIT(SEC_HI_MAX)) u_sh (.clk(clk), .reset(reset), .en(en_sh), .clr(cnt_clr), .digit(cnt.sh), .at_limit(lim_sh));
   bcd_digit_en #(.LIMIT(MIN_LO_MAX)) u_ml (.clk(clk), .reset(reset), .en(en_ml), .clr(cnt_clr), .digit(cnt.ml), .at_limit(lim_ml));
   bcd_digit_en #(.LIMIT(MIN_HI_MAX)) u_mh (.clk(clk), .reset(reset), .en(en_mh), .clr(cnt_clr), .digit(cnt.mh), .at_limit(lim_mh));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        lap_reg <= '0;
      else if (lap_load) lap_reg <= cnt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp       <= '0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         disp       <= (state == ST_LAP) ? lap_reg : cnt;
         running    <= (state_next == ST_RUN) || (state_next == ST_LAP);
         lap_active <= (state_next == ST_LAP);
         wrap       <= carry_out;
      end
   end

   assign BCD_SL = disp.sl;
   assign BCD_SH = disp.sh;
   assign BCD_ML = disp.ml;
   assign BCD_MH = disp.mh;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (TICK_DIV 4 and 1) on shared buttons,
// each checked every cycle against a seconds-count reference model.
module tb_stopwatch_ctrl;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_LAP  = 2;
   localparam int M_STOP = 3;

   logic clk, rst_n, bs, bl, bc;
   logic [3:0] sl [2], sh [2], ml [2], mh [2];
   logic run_o [2], lap_o [2], wrap_o [2];

   int divs [2] = '{4, 1};
   int n_tests = 0;
   int n_fail  = 0;

   int m_mode [2], m_secs [2], m_presc [2], m_lap [2], m_disp [2];
   bit m_run [2], m_lapa [2], m_wrap [2];
   bit p_s, p_l, p_c;

   stopwatch_ctrl #(.TICK_DIV(4)) dut4 (
      .clk(clk), .reset(rst_n), .btn_start(bs), .btn_lap(bl), .btn_clear(bc),
      .BCD_SL(sl[0]), .BCD_SH(sh[0]), .BCD_ML(ml[0]), .BCD_MH(mh[0]),
      .running(run_o[0]), .lap_active(lap_o[0]), .wrap(wrap_o[0]));

   stopwatch_ctrl #(.TICK_DIV(1)) dut1 (
      .clk(clk), .reset(rst_n), .btn_start(bs), .btn_lap(bl), .btn_clear(bc),
      .BCD_SL(sl[1]), .BCD_SH(sh[1]), .BCD_ML(ml[1]), .BCD_MH(mh[1]),
      .running(run_o[1]), .lap_active(lap_o[1]), .wrap(wrap_o[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, sec;
      m   = s / 60;
      sec = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   function automatic logic [15:0] obs_disp(input int i);
      return {mh[i], ml[i], sh[i], sl[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = M_IDLE; m_secs[i] = 0; m_presc[i] = 0; m_lap[i] = 0; m_disp[i] = 0;
         m_run[i] = 0; m_lapa[i] = 0; m_wrap[i] = 0;
      end
      p_s = 1; p_l = 1; p_c = 1;
   endtask

   // One clock edge of the reference: seconds as an integer, display as a copy.
   task automatic model_step();
      bit ec, es, el, wc, ws, wl, counting, tick;
      ec = bc && !p_c;
      es = bs && !p_s;
      el = bl && !p_l;
      wc = ec;
      ws = es && !ec;
      wl = el && !es && !ec;
      for (int i = 0; i < 2; i++) begin
         counting  = (m_mode[i] == M_RUN) || (m_mode[i] == M_LAP);
         tick      = counting && (m_presc[i] == divs[i] - 1);
         m_disp[i] = (m_mode[i] == M_LAP) ? m_lap[i] : m_secs[i];
         m_wrap[i] = tick && (m_secs[i] == 3599);
         if (m_mode[i] == M_RUN && wl) m_lap[i] = m_secs[i];
         if (tick) m_secs[i] = (m_secs[i] + 1) % 3600;
         if (counting) m_presc[i] = tick ? 0 : m_presc[i] + 1;
         case (m_mode[i])
            M_IDLE: if (ws) m_mode[i] = M_RUN;
            M_RUN:  if (ws) m_mode[i] = M_STOP; else if (wl) m_mode[i] = M_LAP;
            M_LAP:  if (wl) m_mode[i] = M_RUN;  else if (ws) m_mode[i] = M_STOP;
            default: begin
               if (wc) begin
                  m_mode[i] = M_IDLE; m_secs[i] = 0; m_presc[i] = 0;
               end else if (ws) m_mode[i] = M_RUN;
            end
         endcase
         m_run[i]  = (m_mode[i] == M_RUN) || (m_mode[i] == M_LAP);
         m_lapa[i] = (m_mode[i] == M_LAP);
      end
      p_s = bs; p_l = bl; p_c = bc;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("disp_div%0d", divs[i]), {16'h0, obs_disp(i)}, {16'h0, to_bcd(m_disp[i])});
         check($sformatf("flags_div%0d", divs[i]), {29'h0, run_o[i], lap_o[i], wrap_o[i]},
               {29'h0, m_run[i], m_lapa[i], m_wrap[i]});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic press(input int which);
      if (which == 0) bs = 1'b1;
      else if (which == 1) bl = 1'b1;
      else bc = 1'b1;
      cycle();
      bs = 1'b0; bl = 1'b0; bc = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++)
         check($sformatf("%s_div%0d", tag, divs[i]),
               {13'h0, obs_disp(i), run_o[i], lap_o[i], wrap_o[i]}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; bs = 1'b0; bl = 1'b0; bc = 1'b0;
      model_reset();
      run(2);
      check_zero("reset_state");

      // Start held through reset release must not start the watch.
      bs = 1'b1;
      #3 rst_n = 1'b1;
      run(5);
      check("held_start_idle", {31'h0, run_o[0]}, 32'h0);
      bs = 1'b0;
      run(1);

      press(0);
      run(41);
      check("count_00_10", {16'h0, obs_disp(0)}, 32'h0010);
      check("running_after_start", {31'h0, run_o[0]}, 32'h1);

      press(0);
      press(2);
      press(0);
      run(28);
      press(1);
      run(48);
      check("lap_frozen_00_07", {16'h0, obs_disp(0)}, 32'h0007);
      check("lap_active_hi", {31'h0, lap_o[0]}, 32'h1);
      press(1);
      run(1);
      check("lap_release_00_19", {16'h0, obs_disp(0)}, 32'h0019);
      check("lap_active_lo", {31'h0, lap_o[0]}, 32'h0);

      press(0);
      run(100);
      press(2);
      run(1);
      check("clear_from_stop", {15'h0, obs_disp(0), run_o[0]}, 32'h0);

      press(0);
      run(10);
      press(2);
      run(5);
      check("clear_in_run_ignored", {31'h0, run_o[0]}, 32'h1);

      // Start and clear on the same edge in STOP: clear wins.
      press(0);
      run(3);
      bs = 1'b1; bc = 1'b1;
      cycle();
      bs = 1'b0; bc = 1'b0;
      run(1);
      check("start_clear_same_edge", {15'h0, obs_disp(0), run_o[0]}, 32'h0);

      press(0);
      run(3599);
      run(1);
      check("wrap_pulse", {30'h0, wrap_o[1], run_o[1]}, 32'h3);
      run(1);
      check("wrap_done", {15'h0, obs_disp(1), wrap_o[1]}, 32'h0);

      // Asynchronous reset mid-count, checked before the next edge.
      run(17);
      @(posedge clk);
      model_step();
      #1 compare_all();
      #1 rst_n = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      run(2);
      #2 rst_n = 1'b1;

      for (int k = 0; k < 700; k++) begin
         if ($urandom_range(5) == 0)  bs = ~bs;
         if ($urandom_range(6) == 0)  bl = ~bl;
         if ($urandom_range(14) == 0) bc = ~bc;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
